// File: rtl/cshm_select_shift_mac_pkg.sv
// Shared types and helpers for the CSHM select-and-shift multiplier.
package cshm_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRECOMP = 2'd1,
      ACC     = 2'd2,
      DONE    = 2'd3
   } state_t;

   // Size of the odd-multiple alphabet x*{1,3,...,15}.
   localparam int ALPHA_N = 8;

   // A nibble pair is usable only when (2*sel+1) << sh still fits in a nibble.
   function automatic logic nib_valid(input logic [2:0] sel, input logic [2:0] sh);
      logic [7:0] v_mag;
      v_mag = {4'd0, sel, 1'b1} << sh;
      if (sh > 3'd3) begin
         return 1'b0;
      end else begin
         return (v_mag <= 8'd15);
      end
   endfunction

   // Accumulator/result width: sample + coefficient magnitude + sign headroom.
   function automatic int result_w(input int xw, input int nib);
      return xw + 4 * nib + 1;
   endfunction

endpackage

// File: rtl/cshm_select_shift_mac_if.sv
// Request/response bundle between the coefficient encoder side and the multiplier.
interface cshm_select_shift_mac_if #(
   parameter int XW  = 8,
   parameter int NIB = 2
);
   logic                   start;
   logic signed [XW-1:0]   x;
   logic [3*NIB-1:0]       coef_shift;
   logic [3*NIB-1:0]       coef_select;
   logic [NIB-1:0]         coef_zero;
   logic                   coef_sign;
   logic                   busy;
   logic                   done;
   logic signed [XW+4*NIB:0] result;
   logic                   err;

   modport master (
      output start, x, coef_shift, coef_select, coef_zero, coef_sign,
      input  busy, done, result, err
   );

   modport slave (
      input  start, x, coef_shift, coef_select, coef_zero, coef_sign,
      output busy, done, result, err
   );
endinterface

// File: rtl/cshm_select_shift_mac_precomputer.sv
// Combinational odd-multiple bank: o_alpha[k] = x*(2k+1), built from shifts and adds.
module cshm_precomputer
   import cshm_pkg::*;
#(
   parameter int XW = 8
) (
   input  logic signed [XW-1:0]             i_x,
   output logic [ALPHA_N-1:0][XW+3:0]       o_alpha
);
   localparam int AW = XW + 4;

   logic signed [AW-1:0] w_x1;
   logic signed [AW-1:0] w_x2;
   logic signed [AW-1:0] w_x4;
   logic signed [AW-1:0] w_x8;
   logic signed [AW-1:0] w_x16;

   assign w_x1  = {{4{i_x[XW-1]}}, i_x};
   assign w_x2  = w_x1 << 1;
   assign w_x4  = w_x1 << 2;
   assign w_x8  = w_x1 << 3;
   // x*16 may wrap transiently; x*15 = x*16 - x still lands in range modulo 2^AW.
   assign w_x16 = w_x1 << 4;

   // Form each odd multiple from the power-of-two partials.
   always_comb begin
      o_alpha[0] = w_x1;
      o_alpha[1] = w_x2 + w_x1;
      o_alpha[2] = w_x4 + w_x1;
      o_alpha[3] = w_x8 - w_x1;
      o_alpha[4] = w_x8 + w_x1;
      o_alpha[5] = w_x8 + w_x2 + w_x1;
      o_alpha[6] = w_x8 + w_x4 + w_x1;
      o_alpha[7] = w_x16 - w_x1;
   end
endmodule

// File: rtl/cshm_select_shift_mac.sv
// Sequential select-and-shift multiplier: one encoded coefficient nibble per cycle.
module cshm_select_shift_mac
   import cshm_pkg::*;
#(
   parameter int XW  = 8,
   parameter int NIB = 2
) (
   input logic                    clk,
   input logic                    reset,
   cshm_select_shift_mac_if.slave bus
);
   localparam int RW = result_w(XW, NIB);
   localparam int AW = XW + 4;
   localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NIB - 1);

   state_t                       r_state;
   state_t                       w_next;
   logic signed [XW-1:0]         r_x;
   logic [3*NIB-1:0]             r_shift;
   logic [3*NIB-1:0]             r_sel;
   logic [NIB-1:0]               r_zero;
   logic                         r_sign;
   logic [ALPHA_N-1:0][AW-1:0]   r_alpha;
   logic [ALPHA_N-1:0][AW-1:0]   w_alpha;
   logic [IW-1:0]                r_idx;
   logic signed [RW-1:0]         r_acc;
   logic signed [RW-1:0]         r_result;
   logic                         r_busy;
   logic                         r_done;
   logic                         r_err;

   logic [2:0]                   w_sh;
   logic [2:0]                   w_sel;
   logic                         w_zero;
   logic                         w_bad;
   logic [AW-1:0]                w_alpha_sel;
   logic signed [RW-1:0]         w_term_ext;
   logic signed [RW-1:0]         w_term;

   cshm_precomputer #(.XW(XW)) u_precomp (
      .i_x     (r_x),
      .o_alpha (w_alpha)
   );

   assign bus.busy   = r_busy;
   assign bus.done   = r_done;
   assign bus.result = r_result;
   assign bus.err    = r_err;

   // Current nibble's term: selected odd multiple, shifted in-nibble then to nibble position.
   always_comb begin
      w_sh        = r_shift[3*int'(r_idx) +: 3];
      w_sel       = r_sel[3*int'(r_idx) +: 3];
      w_zero      = r_zero[r_idx];
      w_bad       = !w_zero && !nib_valid(w_sel, w_sh);
      w_alpha_sel = r_alpha[w_sel];
      w_term_ext  = {{(RW-AW){w_alpha_sel[AW-1]}}, w_alpha_sel};
      if (w_zero || w_bad) begin
         w_term = {RW{1'b0}};
      end else begin
         w_term = (w_term_ext << w_sh) << {r_idx, 2'b00};
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // FSM next-state: one precompute cycle, NIB accumulate cycles, one finish cycle.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (bus.start) begin
               w_next = PRECOMP;
            end else begin
               w_next = IDLE;
            end
         end
         PRECOMP: w_next = ACC;
         ACC: begin
            if (r_idx == LAST_IDX) begin
               w_next = DONE;
            end else begin
               w_next = ACC;
            end
         end
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Datapath: operand capture, alphabet bank, accumulation, sign fix-up and flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_x      <= {XW{1'b0}};
         r_shift  <= {(3*NIB){1'b0}};
         r_sel    <= {(3*NIB){1'b0}};
         r_zero   <= {NIB{1'b0}};
         r_sign   <= 1'b0;
         r_alpha  <= '0;
         r_idx    <= {IW{1'b0}};
         r_acc    <= {RW{1'b0}};
         r_result <= {RW{1'b0}};
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_x     <= bus.x;
                  r_shift <= bus.coef_shift;
                  r_sel   <= bus.coef_select;
                  r_zero  <= bus.coef_zero;
                  r_sign  <= bus.coef_sign;
                  r_acc   <= {RW{1'b0}};
                  r_err   <= 1'b0;
                  r_idx   <= {IW{1'b0}};
                  r_busy  <= 1'b1;
               end
            end
            PRECOMP: begin
               r_alpha <= w_alpha;
               r_idx   <= {IW{1'b0}};
            end
            ACC: begin
               r_acc <= r_acc + w_term;
               r_idx <= r_idx + IW'(1);
               if (w_bad) begin
                  r_err <= 1'b1;
               end
            end
            DONE: begin
               r_result <= r_sign ? -r_acc : r_acc;
               r_done   <= 1'b1;
               r_busy   <= 1'b0;
            end
            default: begin
               r_busy <= 1'b0;
            end
         endcase
      end
   end
endmodule
